sirali_kilit_acici: RTL and testbench

Clocked, parametrised successor to the combinational lock opener. It keeps a registered dial position that moves modulo `KADRAN` on right and left step commands. It checks a multi-stage combination one confirm at a time and opens only after every stage matches in order. It counts wrong confirms and enforces a timed lockout after `MAX_HATA` failures.

---
 rtl/sirali_kilit_acici_pkg.sv | 14 +
 rtl/sirali_kilit_acici_kadran_adim.sv | 40 ++++
 rtl/sirali_kilit_acici.sv | 128 ++++++++++++
 tb/tb_sirali_kilit_acici.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sirali_kilit_acici_pkg.sv
// Shared definitions for the sequential lock opener.
// State encodings and dial direction constants.
package sirali_kilit_acici_pkg;

    typedef enum logic [1:0] {
        BEKLE   = 2'd0,
        ACIK    = 2'd1,
        KILITLI = 2'd2
    } durum_t;

    localparam logic YON_SAG = 1'b0;
    localparam logic YON_SOL = 1'b1;

endpackage

// File: rtl/sirali_kilit_acici_kadran_adim.sv
// Combinational modular step of the dial position.
// Right adds SAG_BIRIM*adim, left retreats SOL_BIRIM*adim, both mod KADRAN.
module kadran_adim
    import sirali_kilit_acici_pkg::*;
#(
    parameter int KADRAN    = 40,
    parameter int SAG_BIRIM = 5,
    parameter int SOL_BIRIM = 10,
    parameter int ADIM_W    = 3,
    parameter int KONUM_W   = $clog2(KADRAN)
) (
    input  logic [KONUM_W-1:0] konum,
    input  logic               yon,
    input  logic [ADIM_W-1:0]  adim,
    output logic [KONUM_W-1:0] yeni_konum
);

    localparam logic [31:0] K  = 32'(KADRAN);
    localparam logic [31:0] SA = 32'(SAG_BIRIM);
    localparam logic [31:0] SO = 32'(SOL_BIRIM);

    // 32-bit intermediates so no product or sum truncates before the modulo
    logic [31:0] sag_top;
    logic [31:0] sol_geri;
    logic [31:0] sol_top;
    logic [31:0] sonuc;

    always_comb begin
        sag_top  = 32'(konum) + SA * 32'(adim);
        sol_geri = (SO * 32'(adim)) % K;
        sol_top  = 32'(konum) + K - sol_geri;
        if (yon == YON_SOL) begin
            sonuc = sol_top % K;
        end else begin
            sonuc = sag_top % K;
        end
        yeni_konum = KONUM_W'(sonuc);
    end

endmodule

// File: rtl/sirali_kilit_acici.sv
// Clocked multi-stage combination lock with dial, error count and lockout.
// FSM, stage/error/penalty counters and all outputs are registered here.
module sirali_kilit_acici
    import sirali_kilit_acici_pkg::*;
#(
    parameter int KADRAN    = 40,
    parameter int SAG_BIRIM = 5,
    parameter int SOL_BIRIM = 10,
    parameter int ADIM_W    = 3,
    parameter int ASAMA     = 3,
    parameter int MAX_HATA  = 3,
    parameter int CEZA_SURE = 8,
    parameter int KONUM_W   = $clog2(KADRAN),
    parameter int ASAMA_W   = $clog2(ASAMA + 1),
    parameter int HATA_W    = $clog2(MAX_HATA + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hamle_gecerli,
    input  logic                     hamle_yon,
    input  logic [ADIM_W-1:0]        hamle_adim,
    input  logic                     onayla,
    input  logic                     kapat,
    input  logic [ASAMA*KONUM_W-1:0] kilit_sifre,
    output logic [KONUM_W-1:0]       kadran_konum,
    output logic [ASAMA_W-1:0]       asama,
    output logic                     kilit_acik,
    output logic                     kilitli,
    output logic [HATA_W-1:0]        hata_sayisi
);

    localparam int CEZA_W = (CEZA_SURE > 1) ? $clog2(CEZA_SURE) : 1;

    durum_t              durum;
    logic [CEZA_W-1:0]   ceza;
    logic [KONUM_W-1:0]  yeni_konum;
    logic [KONUM_W-1:0]  kod;
    logic                eslesme;
    logic                son_asama;
    logic [HATA_W-1:0]   hata_art;

    kadran_adim #(
        .KADRAN    (KADRAN),
        .SAG_BIRIM (SAG_BIRIM),
        .SOL_BIRIM (SOL_BIRIM),
        .ADIM_W    (ADIM_W),
        .KONUM_W   (KONUM_W)
    ) u_kadran_adim (
        .konum      (kadran_konum),
        .yon        (hamle_yon),
        .adim       (hamle_adim),
        .yeni_konum (yeni_konum)
    );

    // Stage code select; out-of-range codes can never equal the dial
    always_comb begin
        kod = '0;
        for (int i = 0; i < ASAMA; i++) begin
            if (asama == ASAMA_W'(i)) begin
                kod = kilit_sifre[i*KONUM_W +: KONUM_W];
            end
        end
        eslesme   = (kod == kadran_konum) && (32'(kod) < 32'(KADRAN));
        son_asama = (asama == ASAMA_W'(ASAMA - 1));
        hata_art  = hata_sayisi + HATA_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum        <= BEKLE;
            kadran_konum <= '0;
            asama        <= '0;
            kilit_acik   <= 1'b0;
            kilitli      <= 1'b0;
            hata_sayisi  <= '0;
            ceza         <= '0;
        end else begin
            if (hamle_gecerli && durum != KILITLI) begin
                kadran_konum <= yeni_konum;
            end
            unique case (durum)
                BEKLE: begin
                    if (onayla) begin
                        if (eslesme) begin
                            if (son_asama) begin
                                durum       <= ACIK;
                                kilit_acik  <= 1'b1;
                                asama       <= ASAMA_W'(ASAMA);
                                hata_sayisi <= '0;
                            end else begin
                                asama <= asama + ASAMA_W'(1);
                            end
                        end else begin
                            asama       <= '0;
                            hata_sayisi <= hata_art;
                            if (hata_art == HATA_W'(MAX_HATA)) begin
                                durum   <= KILITLI;
                                kilitli <= 1'b1;
                                ceza    <= CEZA_W'(CEZA_SURE - 1);
                            end
                        end
                    end
                end
                ACIK: begin
                    if (kapat) begin
                        durum      <= BEKLE;
                        kilit_acik <= 1'b0;
                        asama      <= '0;
                    end
                end
                KILITLI: begin
                    if (ceza == '0) begin
                        durum       <= BEKLE;
                        kilitli     <= 1'b0;
                        hata_sayisi <= '0;
                        asama       <= '0;
                    end else begin
                        ceza <= ceza - CEZA_W'(1);
                    end
                end
                default: begin
                    durum <= BEKLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sirali_kilit_acici.sv
// Directed bench for sirali_kilit_acici with default parameters.
// Table of dial moves plus hand-written open, lockout and reset sequences.
module tb_sirali_kilit_acici;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hamle_gecerli = 1'b0;
    logic        hamle_yon = 1'b0;
    logic [2:0]  hamle_adim = '0;
    logic        onayla = 1'b0;
    logic        kapat = 1'b0;
    logic [17:0] kilit_sifre = '0;
    logic [5:0]  kadran_konum;
    logic [1:0]  asama;
    logic        kilit_acik;
    logic        kilitli;
    logic [1:0]  hata_sayisi;

    int toplam = 0;
    int hatali = 0;

    typedef struct {
        bit sifirla;
        bit yon;
        int adim;
        int beklenen;
    } vek_t;

    vek_t tablo[$];

    sirali_kilit_acici dut (
        .clk           (clk),
        .rst           (rst),
        .hamle_gecerli (hamle_gecerli),
        .hamle_yon     (hamle_yon),
        .hamle_adim    (hamle_adim),
        .onayla        (onayla),
        .kapat         (kapat),
        .kilit_sifre   (kilit_sifre),
        .kadran_konum  (kadran_konum),
        .asama         (asama),
        .kilit_acik    (kilit_acik),
        .kilitli       (kilitli),
        .hata_sayisi   (hata_sayisi)
    );

    always #5 clk = ~clk;

    function automatic int mod40(input int x);
        return ((x % 40) + 40) % 40;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kontrol(input string ad, input int gercek, input int beklenen);
        toplam++;
        if (gercek != beklenen) begin
            hatali++;
            $display("FAIL %s: got %0d expected %0d", ad, gercek, beklenen);
        end
    endtask

    task automatic sifirla();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic hamle(input bit yon, input int adim);
        hamle_gecerli = 1'b1;
        hamle_yon     = yon;
        hamle_adim    = 3'(adim);
        tick();
        hamle_gecerli = 1'b0;
    endtask

    task automatic onay();
        onayla = 1'b1;
        tick();
        onayla = 1'b0;
    endtask

    task automatic hepsi_sifir(input string ad);
        kontrol({ad, " konum"}, int'(kadran_konum), 0);
        kontrol({ad, " asama"}, int'(asama), 0);
        kontrol({ad, " acik"}, int'(kilit_acik), 0);
        kontrol({ad, " kilitli"}, int'(kilitli), 0);
        kontrol({ad, " hata"}, int'(hata_sayisi), 0);
    endtask

    initial begin
        int n;

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 4; b++) begin
                tablo.push_back(vek_t'{1'b1, 1'b0, a, mod40(5 * a)});
                tablo.push_back(vek_t'{1'b0, 1'b1, b, mod40(5 * a - 10 * b)});
            end
        end
        tablo.push_back(vek_t'{1'b1, 1'b0, 7, 35});
        tablo.push_back(vek_t'{1'b0, 1'b0, 7, 30});
        tablo.push_back(vek_t'{1'b1, 1'b1, 3, 10});
        tablo.push_back(vek_t'{1'b1, 1'b0, 0, 0});
        tablo.push_back(vek_t'{1'b1, 1'b0, 2, 10});
        tablo.push_back(vek_t'{1'b0, 1'b1, 1, 0});

        tick();
        tick();
        rst = 1'b0;
        hepsi_sifir("reset");

        foreach (tablo[i]) begin
            if (tablo[i].sifirla) sifirla();
            hamle(tablo[i].yon, tablo[i].adim);
            kontrol($sformatf("move[%0d]", i), int'(kadran_konum), tablo[i].beklenen);
        end

        // open sequence with codes {5,25,0}
        kilit_sifre = {6'd0, 6'd25, 6'd5};
        sifirla();
        hamle(1'b0, 1);
        onay();
        kontrol("open asama1", int'(asama), 1);
        hamle(1'b1, 2);
        kontrol("open konum25", int'(kadran_konum), 25);
        onay();
        kontrol("open asama2", int'(asama), 2);
        hamle(1'b0, 3);
        kontrol("open konum0", int'(kadran_konum), 0);
        kontrol("open not yet", int'(kilit_acik), 0);
        onay();
        kontrol("open acik", int'(kilit_acik), 1);
        kontrol("open asama3", int'(asama), 3);
        onay();
        kontrol("open onay ignored", int'(kilit_acik), 1);
        kapat = 1'b1;
        tick();
        kapat = 1'b0;
        kontrol("close acik", int'(kilit_acik), 0);
        kontrol("close asama", int'(asama), 0);
        kontrol("close konum", int'(kadran_konum), 0);
        kapat = 1'b1;
        tick();
        kapat = 1'b0;
        kontrol("kapat in bekle", int'(asama), 0);

        // wrong confirm mid-sequence falls back to stage 0
        hamle(1'b0, 1);
        onay();
        kontrol("mid asama1", int'(asama), 1);
        onay();
        kontrol("mid asama0", int'(asama), 0);
        kontrol("mid hata1", int'(hata_sayisi), 1);

        // lockout: three wrong confirms at position 0
        sifirla();
        onay();
        kontrol("lock hata1", int'(hata_sayisi), 1);
        onay();
        kontrol("lock hata2", int'(hata_sayisi), 2);
        kontrol("lock not yet", int'(kilitli), 0);
        onay();
        kontrol("lock hata3", int'(hata_sayisi), 3);
        n = 0;
        while (kilitli && n < 20) begin
            n++;
            onayla = 1'b1;
            hamle(1'b0, 1);
            onayla = 1'b0;
        end
        kontrol("lock cycles", n, 8);
        kontrol("lock hata clr", int'(hata_sayisi), 0);
        kontrol("lock konum", int'(kadran_konum), 0);
        kontrol("lock asama", int'(asama), 0);
        hamle(1'b0, 1);
        kontrol("after lock move", int'(kadran_konum), 5);

        // same-cycle confirm and move, then kapat beats onayla
        kilit_sifre = {6'd10, 6'd10, 6'd5};
        sifirla();
        hamle(1'b0, 1);
        onayla = 1'b1;
        hamle(1'b0, 1);
        onayla = 1'b0;
        kontrol("sim asama", int'(asama), 1);
        kontrol("sim konum", int'(kadran_konum), 10);
        onay();
        onay();
        kontrol("sim acik", int'(kilit_acik), 1);
        kapat  = 1'b1;
        onayla = 1'b1;
        tick();
        kapat  = 1'b0;
        onayla = 1'b0;
        kontrol("sim relock", int'(kilit_acik), 0);
        kontrol("sim relock asama", int'(asama), 0);

        // reset during lockout
        kilit_sifre = {6'd0, 6'd0, 6'd20};
        sifirla();
        hamle(1'b0, 1);
        onay();
        onay();
        onay();
        tick();
        kontrol("mid lock", int'(kilitli), 1);
        sifirla();
        hepsi_sifir("rst lock");

        $display("[TB] %0d tests run, %0d failed", toplam, hatali);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
